// File: rtl/calc_pkg.sv
// Shared constants for the accumulator calculator: datapath width and ALU op codes.
package calc_pkg;

  localparam int WIDTH = 16;

  // Shift amount is always the low nibble of operand B.
  localparam int SHAMT_W = 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_LSL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

endpackage

// File: rtl/calc_alu.sv
// Purely combinational 8-function ALU: y = f(a, b, op).
// Arithmetic wraps modulo 2^WIDTH; no flags are produced.
module calc_alu
  import calc_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] y
);

  logic [SHAMT_W-1:0] w_shamt;
  assign w_shamt = b[SHAMT_W-1:0];

  // Select the result for the current op; every path assigns y.
  always_comb begin
    y = '0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_ADD: y = a + b;
      OP_ASR: y = W'($signed(a) >>> w_shamt);
      OP_LSL: y = a << w_shamt;
      OP_SLT: y[0] = ($signed(a) < $signed(b));
      OP_SUB: y = a - b;
      OP_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/calc.sv
// Accumulator calculator top level: switches feed operand B, the accumulator
// is operand A and drives the LEDs directly. btnd is a level commit enable.
module calc
  import calc_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         btnu,
  input  logic         btnd,
  input  logic         btnl,
  input  logic         btnc,
  input  logic         btnr,
  input  logic [W-1:0] sw,
  output logic [W-1:0] led
);

  logic [W-1:0] r_acc;
  logic [W-1:0] w_alu_y;
  logic [2:0]   w_op;

  assign w_op = {btnl, btnc, btnr};

  calc_alu #(
    .W(W)
  ) u_alu (
    .a  (r_acc),
    .b  (sw),
    .op (w_op),
    .y  (w_alu_y)
  );

  // Accumulator: async clear on btnu (dominates), load ALU result on every edge with btnd high.
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      r_acc <= '0;
    end else if (btnd) begin
      r_acc <= w_alu_y;
    end
  end

  assign led = r_acc;

endmodule

// File: tb/tb_calc.sv
// Randomized scoreboard bench for calc: stimulus pushes expected LED values
// tagged with the cycle they must appear in; a monitor checks them on negedge.
module tb_calc;

  logic        clk = 1'b0;
  logic        btnu, btnd, btnl, btnc, btnr;
  logic [15:0] sw;
  logic [15:0] led;

  calc dut (
    .clk  (clk),
    .btnu (btnu),
    .btnd (btnd),
    .btnl (btnl),
    .btnc (btnc),
    .btnr (btnr),
    .sw   (sw),
    .led  (led)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int          cyc;
    logic [15:0] exp;
    logic [2:0]  op;
    logic [15:0] b;
    int          kind;   // 0 commit, 1 idle, 2 reset
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic [15:0] model_acc;

  // Reference ALU written with plain integer arithmetic.
  function automatic logic [15:0] ref_alu(input longint a, input longint b, input int op);
    longint as_, bs_, n, p, r;
    as_ = (a >= 32768) ? a - 65536 : a;
    bs_ = (b >= 32768) ? b - 65536 : b;
    n   = b % 16;
    p   = longint'(1) << n;
    r   = 0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: r = (a + b) % 65536;
      3: begin
           if (as_ >= 0) r = as_ / p;
           else          r = -((-as_ + p - 1) / p);
           r = (r + 65536) % 65536;
         end
      4: r = (a * p) % 65536;
      5: r = (as_ < bs_) ? 1 : 0;
      6: r = (a - b + 65536) % 65536;
      7: r = a ^ b;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic push(input int c, input logic [15:0] e, input logic [2:0] op,
                      input logic [15:0] b, input int kind);
    exp_t x;
    x.cyc = c; x.exp = e; x.op = op; x.b = b; x.kind = kind;
    q.push_back(x);
  endtask

  task automatic do_commit(input logic [2:0] op, input logic [15:0] b);
    @(posedge clk); #1;
    btnu = 1'b0; btnd = 1'b1; {btnl, btnc, btnr} = op; sw = b;
    model_acc = ref_alu(model_acc, b, op);
    push(cycle + 1, model_acc, op, b, 0);
  endtask

  task automatic do_idle(input logic [2:0] op, input logic [15:0] b);
    @(posedge clk); #1;
    btnu = 1'b0; btnd = 1'b0; {btnl, btnc, btnr} = op; sw = b;
    push(cycle + 1, model_acc, op, b, 1);
  endtask

  // Short btnu pulse entirely between clock edges; a synchronous clear would miss it.
  task automatic do_async_pulse();
    @(posedge clk); @(negedge clk); #1;
    btnd = 1'b0; btnu = 1'b1;
    #2;
    btnu = 1'b0;
    model_acc = 16'h0000;
    push(cycle + 1, model_acc, 3'b000, sw, 2);
  endtask

  // btnu and btnd both high across an edge, with an ADD that would change acc.
  task automatic do_reset_and_enter(input logic [15:0] b);
    @(posedge clk); @(negedge clk); #1;
    btnu = 1'b1; btnd = 1'b1; {btnl, btnc, btnr} = 3'b010; sw = b;
    model_acc = 16'h0000;
    push(cycle + 1, model_acc, 3'b010, b, 2);
  endtask

  // Monitor: compare every expectation due by this cycle against the LEDs.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cycle) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (e.cyc < cycle || led !== e.exp) begin
        bad++;
        $display("FAIL chk kind=%0d op=%0d sw=%h cyc=%0d due=%0d led=%h want=%h",
                 e.kind, e.op, e.b, cycle, e.cyc, led, e.exp);
      end else begin
        $display("ok   chk kind=%0d op=%0d sw=%h cyc=%0d led=%h",
                 e.kind, e.op, e.b, cycle, led);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, led=%h want=finish", led);
    $fatal(1, "timeout");
  end

  initial begin
    btnu = 1'b1; btnd = 1'b0; btnl = 1'b0; btnc = 1'b0; btnr = 1'b0; sw = 16'h0;
    model_acc = 16'h0000;
    @(posedge clk); #1;
    push(cycle, 16'h0000, 3'b000, sw, 2);   // reset state while btnu held

    // Load something nonzero, then clear it with an async pulse.
    do_commit(3'b010, 16'habcd);
    do_async_pulse();
    do_idle(3'b010, 16'h1111);

    // Basic sequence from 0.
    do_commit(3'b010, 16'h354a);
    do_commit(3'b110, 16'h1234);
    do_commit(3'b001, 16'h1001);
    do_commit(3'b000, 16'h0f0f);
    do_commit(3'b111, 16'h1fa2);

    // Shifts, including a shift amount whose low nibble is zero.
    do_async_pulse();
    do_commit(3'b010, 16'h9a54);
    do_commit(3'b100, 16'h0004);
    do_commit(3'b011, 16'h0001);
    do_commit(3'b011, 16'h0010);

    // Signed compare and wrap-around.
    do_commit(3'b101, 16'h46ff);
    do_commit(3'b000, 16'h0000);
    do_commit(3'b010, 16'h46ff);
    do_commit(3'b101, 16'hd2a0);
    do_commit(3'b010, 16'hffff);
    do_commit(3'b010, 16'h0001);
    do_commit(3'b110, 16'h0001);

    // Level enable held three edges, idle hold, reset dominating enter.
    do_async_pulse();
    do_commit(3'b010, 16'h0001);
    do_commit(3'b010, 16'h0001);
    do_commit(3'b010, 16'h0001);
    do_idle(3'b111, 16'hffff);
    do_idle(3'b110, 16'h1234);
    do_reset_and_enter(16'h5555);
    do_idle(3'b010, 16'h0001);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [15:0] b;
      logic [2:0]  op;
      r  = $urandom_range(0, 99);
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: b = 16'h0000;
        1: b = 16'hffff;
        2: b = 16'h8000;
        3: b = 16'($urandom_range(0, 31));
        default: b = 16'($urandom);
      endcase
      if (r < 3)       do_async_pulse();
      else if (r < 6)  do_reset_and_enter(b);
      else if (r < 25) do_idle(op, b);
      else             do_commit(op, b);
    end

    @(posedge clk); #1;
    btnd = 1'b0; btnu = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
